mux4_rr_sched: RTL and testbench
================================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4-to-1 single-bit mux path between four requesters.
- Arbitrates req[3:0] and drives the mux select {s1,s0}.
- Enforces a maximum grant tenure and registers the selected data bit with a valid flag.
- Sits directly in front of the mux4to1 datapath; sel[1] maps to s1 and sel[0] maps to s0.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may hold a grant. Legal range 1..15.
- CNT_W, 4: width of the tenure counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i is requester i. Any value other than 1'b1 counts as no request.
- din  input  4  data bit per requester; din[i] is mux input in_i.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select {s1,s0} = index of the granted requester, registered.
- busy  output  1  a grant is active, registered.
- dout  output  1  registered copy of din[sel] while busy.
- dout_valid  output  1  dout holds data from a granted cycle.

Behaviour:
- Reset (async assert, sync release): gnt=0, sel=2'b00, busy=0, dout=0, dout_valid=0, hold_cnt=0, ptr=2'd3. With ptr=3, requester 0 has first priority.
- States: IDLE (busy=0) and GRANT (busy=1). Only these two states exist.
- Priority search: start at ptr+1 mod 4 and wrap through 4 entries. The first index with req=1 wins.
- IDLE:
  - If any req=1 at a rising edge, the winner w takes effect that edge: gnt=1<<w, sel=w, busy=1, hold_cnt=1, ptr=w. Next state GRANT.
  - Otherwise stay in IDLE with gnt=0. sel holds its last value.
- GRANT, holding index c, with release = (req[c]!=1) || (hold_cnt==MAX_HOLD):
  - release=0: keep the grant and increment hold_cnt.
  - release=1 and another eligible request exists: re-arbitrate in the same edge. Search starts at c+1, so c gets lowest priority; c may win only if it is the sole requester and req[c]=1. The new winner w is applied: gnt, sel, ptr=w, hold_cnt=1. There is no bubble cycle.
  - release=1 and no request: go to IDLE with gnt=0 and busy=0.
- Wrap-around:
  - ptr and the search index are mod 4 (3 -> 0).
  - hold_cnt never exceeds MAX_HOLD.
  - With MAX_HOLD=1, a continuously requesting single requester is re-granted every cycle, with hold_cnt reset to 1 each time.
- Data path:
  - Each edge, if busy=1 (before the update), dout <= din[sel] and dout_valid <= 1. Otherwise dout <= 0 and dout_valid <= 0.
  - Latency from a grant edge to the first valid dout is 1 cycle.
  - dout reflects the din bit that was selected during the previous cycle.
- Simultaneous events: a requester dropping req in the same cycle its tenure expires is one release, not two. A new requester arriving at that edge is eligible immediately.
- Invariants: gnt is always zero or one-hot. When busy=1, gnt[sel]=1. When busy=0, gnt=0.
- Reset mid-grant clears all state asynchronously. The first arbitration after release starts again from requester 0.

Test Plan:
- Reset then req=4'b0101 held: grants go 0,0,0,0 (MAX_HOLD=4), then 2 for 4 cycles, then 0. sel follows 0 -> 2 -> 0. busy stays 1 throughout with no idle cycle.
- req=4'b1000 for 2 cycles, then req=0: gnt=4'b1000 for 2 cycles, sel=3, then busy=0. dout_valid=1 for exactly 2 cycles, each lagging its grant cycle by 1.
- Grant 1 active with din=4'b0010: dout=1 one cycle after the grant edge. Change din[1] to 0 and dout=0 one cycle later. Toggling din[0] has no effect on dout.
- All req=4'b1111 for 32 cycles with MAX_HOLD=4: grant order 0,1,2,3,0 with 4 cycles each. No requester is starved and gnt is one-hot every cycle.
- rst_n asserted while gnt=4'b0100: gnt, busy, dout and dout_valid go to 0 immediately, without waiting for a clock edge. After release with req=4'b1100, the first grant is to 2.
- Requester 1 alone with req[1]=1 and MAX_HOLD=1: gnt=4'b0010 every cycle with no bubble. hold_cnt never exceeds 1.

Source files
------------

// File: rtl/mux4_rr_sched_if.sv
// Request/grant/data bundle between four requesters and the round-robin mux scheduler.
// The master side drives requests and data; the slave side is the scheduler.
interface mux4_rr_sched_if;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;
    logic       dout_valid;

    modport master (
        output req, din,
        input  gnt, sel, busy, dout, dout_valid
    );

    modport slave (
        input  req, din,
        output gnt, sel, busy, dout, dout_valid
    );
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a shared 4:1 single-bit mux: limits grant tenure to MAX_HOLD
// cycles, drives the mux select and registers the selected data bit with a valid flag.
module mux4_rr_sched #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_sched_if.slave   bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state, w_nextState;
    logic [3:0]       r_gnt, w_nextGnt;
    logic [1:0]       r_sel, w_nextSel;
    logic [1:0]       r_ptr, w_nextPtr;
    logic [CNT_W-1:0] r_holdCnt, w_nextHold;
    logic             r_dout, r_doutValid;

    logic [1:0]       w_base;
    logic [2:0]       w_search;
    logic             w_found;
    logic [1:0]       w_win;
    logic             w_release;

    // Returns {found, index}: the first requester at or after base+1, wrapping mod 4.
    function automatic logic [2:0] findWinner(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 1; k < 5; k++) begin
            idx = base + 2'(k);
            if (!res[2] && r[idx] == 1'b1) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_base   = (r_state == GRANT) ? r_sel : r_ptr;
    assign w_search = findWinner(bus.req, w_base);
    assign w_found  = w_search[2];
    assign w_win    = w_search[1:0];

    always_comb begin
        w_nextState = r_state;
        w_nextGnt   = r_gnt;
        w_nextSel   = r_sel;
        w_nextPtr   = r_ptr;
        w_nextHold  = r_holdCnt;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextGnt = 4'b0000;
                if (w_found) begin
                    w_nextState = GRANT;
                    w_nextGnt   = 4'b0001 << w_win;
                    w_nextSel   = w_win;
                    w_nextPtr   = w_win;
                    w_nextHold  = CNT_W'(1);
                end
            end
            GRANT: begin
                w_release = (bus.req[r_sel] != 1'b1) || (r_holdCnt == CNT_W'(MAX_HOLD));
                if (!w_release) begin
                    w_nextHold = r_holdCnt + CNT_W'(1);
                end else if (w_found) begin
                    // Search starts past the current holder, so it only wins when alone.
                    w_nextGnt  = 4'b0001 << w_win;
                    w_nextSel  = w_win;
                    w_nextPtr  = w_win;
                    w_nextHold = CNT_W'(1);
                end else begin
                    w_nextState = IDLE;
                    w_nextGnt   = 4'b0000;
                    w_nextHold  = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextGnt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= 4'b0000;
            r_sel     <= 2'b00;
            r_ptr     <= 2'd3;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_gnt     <= w_nextGnt;
            r_sel     <= w_nextSel;
            r_ptr     <= w_nextPtr;
            r_holdCnt <= w_nextHold;
        end
    end

    // Data is captured from the select that was active during the cycle just ending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= 1'b0;
            r_doutValid <= 1'b0;
        end else if (r_state == GRANT) begin
            r_dout      <= bus.din[r_sel];
            r_doutValid <= 1'b1;
        end else begin
            r_dout      <= 1'b0;
            r_doutValid <= 1'b0;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.sel        = r_sel;
    assign bus.busy       = (r_state == GRANT);
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_doutValid;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed self-checking bench for mux4_rr_sched: one DUT at MAX_HOLD=4 and one at MAX_HOLD=1.
module tb_mux4_rr_sched;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    mux4_rr_sched_if bus ();
    mux4_rr_sched_if bus1 ();

    mux4_rr_sched #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mux4_rr_sched #(.MAX_HOLD(1), .CNT_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.din  = 4'b0000;
        bus1.req = 4'b0000;
        bus1.din = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.din  = 4'b0000;
        bus1.req = 4'b0000;
        bus1.din = 4'b0000;
        #2;
        checkCount++;
        if ({bus.gnt, bus.sel, bus.busy, bus.dout, bus.dout_valid} !== 9'b0) begin
            $display("[TB] FAIL reset_state: got gnt=%b sel=%b busy=%b dout=%b valid=%b expected all zero",
                     bus.gnt, bus.sel, bus.busy, bus.dout, bus.dout_valid);
        end else passCount++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_two_requesters();
        int expSeq [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
        logic [3:0] expGnt;
        doReset();
        bus.req = 4'b0101;
        for (int k = 0; k < 12; k++) begin
            tick();
            expGnt = 4'b0001 << expSeq[k];
            checkCount++;
            if (bus.gnt !== expGnt || bus.sel !== 2'(expSeq[k]) || bus.busy !== 1'b1) begin
                $display("[TB] FAIL two_req cycle %0d: got gnt=%b sel=%0d busy=%b expected gnt=%b sel=%0d busy=1",
                         k, bus.gnt, bus.sel, bus.busy, expGnt, expSeq[k]);
            end else passCount++;
        end
        bus.req = 4'b0000;
        tick();
        checkCount++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            $display("[TB] FAIL two_req_release: got busy=%b gnt=%b expected busy=0 gnt=0000", bus.busy, bus.gnt);
        end else passCount++;
    endtask

    task automatic test_single_burst();
        doReset();
        bus.req = 4'b1000;
        tick();
        checkCount++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3 || bus.dout_valid !== 1'b0) begin
            $display("[TB] FAIL burst_c0: got gnt=%b sel=%0d valid=%b expected gnt=1000 sel=3 valid=0",
                     bus.gnt, bus.sel, bus.dout_valid);
        end else passCount++;
        tick();
        checkCount++;
        if (bus.gnt !== 4'b1000 || bus.dout_valid !== 1'b1) begin
            $display("[TB] FAIL burst_c1: got gnt=%b valid=%b expected gnt=1000 valid=1", bus.gnt, bus.dout_valid);
        end else passCount++;
        bus.req = 4'b0000;
        tick();
        checkCount++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.sel !== 2'd3 || bus.dout_valid !== 1'b1) begin
            $display("[TB] FAIL burst_c2: got busy=%b gnt=%b sel=%0d valid=%b expected busy=0 gnt=0000 sel=3 valid=1",
                     bus.busy, bus.gnt, bus.sel, bus.dout_valid);
        end else passCount++;
        tick();
        checkCount++;
        if (bus.dout_valid !== 1'b0) begin
            $display("[TB] FAIL burst_c3: got valid=%b expected valid=0", bus.dout_valid);
        end else passCount++;
    endtask

    task automatic test_data_path();
        doReset();
        bus.req = 4'b0010;
        bus.din = 4'b0010;
        tick();
        checkCount++;
        if (bus.gnt !== 4'b0010 || bus.dout_valid !== 1'b0) begin
            $display("[TB] FAIL data_grant: got gnt=%b valid=%b expected gnt=0010 valid=0", bus.gnt, bus.dout_valid);
        end else passCount++;
        tick();
        checkCount++;
        if (bus.dout !== 1'b1 || bus.dout_valid !== 1'b1) begin
            $display("[TB] FAIL data_one: got dout=%b valid=%b expected dout=1 valid=1", bus.dout, bus.dout_valid);
        end else passCount++;
        bus.din = 4'b0000;
        tick();
        checkCount++;
        if (bus.dout !== 1'b0 || bus.dout_valid !== 1'b1) begin
            $display("[TB] FAIL data_zero: got dout=%b valid=%b expected dout=0 valid=1", bus.dout, bus.dout_valid);
        end else passCount++;
        bus.din = 4'b0001;
        tick();
        checkCount++;
        if (bus.dout !== 1'b0) begin
            $display("[TB] FAIL data_din0_high: got dout=%b expected 0", bus.dout);
        end else passCount++;
        bus.din = 4'b1101;
        tick();
        checkCount++;
        if (bus.dout !== 1'b0) begin
            $display("[TB] FAIL data_other_bits: got dout=%b expected 0", bus.dout);
        end else passCount++;
    endtask

    task automatic test_all_requesters();
        logic [3:0] expGnt;
        int expIdx;
        doReset();
        bus.req = 4'b1111;
        for (int k = 0; k < 32; k++) begin
            tick();
            expIdx = (k / 4) % 4;
            expGnt = 4'b0001 << expIdx;
            checkCount++;
            if (bus.gnt !== expGnt || bus.sel !== 2'(expIdx) || !$onehot(bus.gnt)) begin
                $display("[TB] FAIL all_req cycle %0d: got gnt=%b sel=%0d expected gnt=%b sel=%0d",
                         k, bus.gnt, bus.sel, expGnt, expIdx);
            end else passCount++;
        end
    endtask

    task automatic test_async_reset();
        doReset();
        bus.req = 4'b0100;
        bus.din = 4'b0100;
        tick();
        tick();
        checkCount++;
        if (bus.gnt !== 4'b0100 || bus.dout !== 1'b1 || bus.dout_valid !== 1'b1) begin
            $display("[TB] FAIL async_pre: got gnt=%b dout=%b valid=%b expected gnt=0100 dout=1 valid=1",
                     bus.gnt, bus.dout, bus.dout_valid);
        end else passCount++;
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({bus.gnt, bus.busy, bus.dout, bus.dout_valid} !== 7'b0) begin
            $display("[TB] FAIL async_clear: got gnt=%b busy=%b dout=%b valid=%b expected all zero",
                     bus.gnt, bus.busy, bus.dout, bus.dout_valid);
        end else passCount++;
        bus.req = 4'b1100;
        #1;
        rst_n = 1'b1;
        tick();
        checkCount++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
            $display("[TB] FAIL async_first_grant: got gnt=%b sel=%0d expected gnt=0100 sel=2", bus.gnt, bus.sel);
        end else passCount++;
    endtask

    task automatic test_max_hold_one();
        doReset();
        bus1.req = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkCount++;
            if (bus1.gnt !== 4'b0010 || bus1.busy !== 1'b1 || dut1.r_holdCnt !== 2'd1) begin
                $display("[TB] FAIL hold1 cycle %0d: got gnt=%b busy=%b hold=%0d expected gnt=0010 busy=1 hold=1",
                         k, bus1.gnt, bus1.busy, dut1.r_holdCnt);
            end else passCount++;
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_two_requesters();
        test_single_burst();
        test_data_path();
        test_all_requesters();
        test_async_reset();
        test_max_hold_one();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
